// File: rtl/cart_unlock_host_pkg.sv
// Shared constants and state encoding for the cartridge unlock host and its mapper peer.
// EXPECT_DEFAULT is the single payload constant both ends agree on.
package cart_unlock_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_NAK,
    ST_HUNT,
    ST_SHIFT,
    ST_STOP
  } state_e;

  localparam logic [7:0] ADDR_ACK  = 8'h5A;
  localparam logic [7:0] ADDR_NAK  = 8'hA5;
  localparam logic [7:0] ADDR_IDLE = 8'h00;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [FRAME_BITS-1:0] EXPECT_DEFAULT = 16'h28A0;

  // Address byte the bus carries while the FSM sits in a given state.
  function automatic logic [7:0] addr_for(input state_e s);
    case (s)
      ST_ACK:  return ADDR_ACK;
      ST_NAK:  return ADDR_NAK;
      default: return ADDR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cart_unlock_host_if.sv
// Request/status and cartridge-side signals of the unlock host.
// master = host side, slave = boot controller / mapper side.
interface cart_unlock_host_if;
  logic        start;
  logic        si;
  logic [7:0]  addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] data;
  logic        match;

  modport master (
    input  start, si,
    output addr, busy, done, err, data, match
  );

  modport slave (
    output start, si,
    input  addr, busy, done, err, data, match
  );
endinterface

// File: rtl/cart_bit_rx.sv
// LSB-first 16-bit deserializer: one bit per shift_en cycle, last flags the 16th bit.
// clr zeroes the payload and rewinds the bit counter.
module cart_bit_rx
  import cart_unlock_host_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic                  bit_in,
  output logic [FRAME_BITS-1:0] data,
  output logic                  last
);

  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      data_d[cnt_q] = bit_in;
      cnt_d         = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data = data_q;
  assign last = shift_en && (cnt_q == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/cart_unlock_host.sv
// Drives the 5A/A5 unlock sequence, then hunts for and deserializes the mapper's
// {start, 16-bit payload, stop} frame; START is ignored while busy.
module cart_unlock_host
  import cart_unlock_host_pkg::*;
#(
  parameter int                    TIMEOUT = 8,
  parameter logic [FRAME_BITS-1:0] EXPECT  = EXPECT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  cart_unlock_host_if.master bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e                state_q, state_d;
  logic [7:0]            addr_q, addr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  match_q, match_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  rx_clr, rx_shift, rx_last;
  logic [FRAME_BITS-1:0] rx_data;

  cart_bit_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .clr      (rx_clr),
    .shift_en (rx_shift),
    .bit_in   (bus.si),
    .data     (rx_data),
    .last     (rx_last)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    err_d    = err_q;
    match_d  = match_q;
    tcnt_d   = tcnt_q;
    rx_clr   = 1'b0;
    rx_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACK;
          done_d  = 1'b0;
          err_d   = 1'b0;
          match_d = 1'b0;
          rx_clr  = 1'b1;
        end
      end
      ST_ACK: state_d = ST_NAK;
      ST_NAK: begin
        state_d = ST_HUNT;
        tcnt_d  = '0;
      end
      ST_HUNT: begin
        // A start bit on the last allowed cycle still wins over the timeout.
        if (!bus.si) begin
          state_d = ST_SHIFT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        rx_shift = 1'b1;
        if (rx_last) state_d = ST_STOP;
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        if (!bus.si) begin
          done_d  = 1'b1;
          match_d = (rx_data == EXPECT);
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    addr_d = addr_for(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      match_q <= match_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.addr  = addr_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.match = match_q;
  assign bus.data  = rx_data;

endmodule

// File: tb/tb_cart_unlock_host.sv
// Bench for cart_unlock_host: a mapper model answers the A5 address with a framed payload;
// expected outputs per cycle come from the transaction's delay/payload/stop-bit choice.
module tb_cart_unlock_host;

  localparam int          TO  = 8;
  localparam logic [15:0] EXP = 16'h28A0;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  cart_unlock_host_if bus ();

  cart_unlock_host #(.TIMEOUT(TO), .EXPECT(EXP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mapper model: on seeing A5 it queues idle ones, start bit, payload LSB first, stop bit.
  bit          m_q[$];
  int          m_d;
  logic [15:0] m_p;
  bit          m_bad;
  bit          m_resp;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.addr == 8'hA5 && m_resp) begin
        m_q.delete();
        for (int i = 0; i < m_d; i++) m_q.push_back(1'b1);
        m_q.push_back(1'b0);
        for (int i = 0; i < 16; i++) m_q.push_back(m_p[i]);
        m_q.push_back(m_bad);
      end
    end
  end

  initial begin
    bus.si = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (m_q.size() > 0) bus.si = m_q.pop_front();
      else bus.si = 1'b1;
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm, input int k);
    chk({nm, "_addr"}, k, 32'(bus.addr), 32'h00);
    chk({nm, "_busy"}, k, 32'(bus.busy), 32'h0);
    chk({nm, "_done"}, k, 32'(bus.done), 32'h0);
    chk({nm, "_err"},  k, 32'(bus.err),  32'h0);
    chk({nm, "_match"}, k, 32'(bus.match), 32'h0);
    chk({nm, "_data"}, k, 32'(bus.data), 32'h0);
  endtask

  // One unlock transaction; k counts edges after the one that accepted START (T0).
  task automatic run(input int d, input logic [15:0] p, input bit bad, input bit resp,
                     input int k_extra, input int k_rst,
                     output int obs_end, output logic [15:0] obs_data);
    int  exp_end;
    bit  timeout;
    logic [7:0] e_addr;
    m_d = d; m_p = p; m_bad = bad; m_resp = resp;
    m_q.delete();
    timeout  = !(resp && d < TO);
    exp_end  = timeout ? 2 + TO : 20 + d;
    obs_end  = -1;
    obs_data = 16'h0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 0; k <= exp_end + 2; k++) begin
      bus.start = (k == k_extra);
      if (k == k_rst) rst = 1'b1;
      @(negedge clk);
      if (k == k_rst) begin
        chk_reset_vals("rst_mid", k);
        obs_end  = k;
        obs_data = bus.data;
        rst      = 1'b0;
        m_q.delete();
        break;
      end
      e_addr = (k == 0) ? 8'h5A : (k == 1) ? 8'hA5 : 8'h00;
      chk("addr", k, 32'(bus.addr), 32'(e_addr));
      chk("busy", k, 32'(bus.busy), 32'(k < exp_end));
      if (k < exp_end) begin
        chk("done", k, 32'(bus.done), 32'h0);
        chk("err", k, 32'(bus.err), 32'h0);
        chk("match", k, 32'(bus.match), 32'h0);
      end else begin
        chk("done", k, 32'(bus.done), 32'(!timeout && !bad));
        chk("err", k, 32'(bus.err), 32'(timeout || bad));
        chk("match", k, 32'(bus.match), 32'(!timeout && !bad && p == EXP));
        if (timeout) chk("data", k, 32'(bus.data), 32'h0);
        else if (!bad) chk("data", k, 32'(bus.data), 32'(p));
      end
      if (obs_end < 0 && !bus.busy) begin
        obs_end  = k;
        obs_data = bus.data;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    m_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int          oe;
  logic [15:0] od;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    m_resp    = 1'b0;
    m_d       = 0;
    m_p       = '0;
    m_bad     = 1'b0;
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("por", 0);
    rst = 1'b0;

    run(0, 16'h28A0, 1'b0, 1'b1, -1, -1, oe, od);
    chk("t_exp_end", 0, 32'(oe), 32'd20);
    chk("t_exp_data", 0, 32'(od), 32'h28A0);
    chk("t_exp_match", 0, 32'(bus.match), 32'h1);

    run(0, 16'h1234, 1'b0, 1'b1, -1, -1, oe, od);
    chk("t_1234_data", 0, 32'(od), 32'h1234);
    chk("t_1234_match", 0, 32'(bus.match), 32'h0);
    chk("t_1234_done", 0, 32'(bus.done), 32'h1);

    run(0, 16'h28A0, 1'b0, 1'b0, -1, -1, oe, od);
    chk("t_to_end", 0, 32'(oe), 32'd10);
    chk("t_to_err", 0, 32'(bus.err), 32'h1);
    chk("t_to_data", 0, 32'(od), 32'h0);

    run(0, 16'h28A0, 1'b1, 1'b1, -1, -1, oe, od);
    chk("t_bad_err", 0, 32'(bus.err), 32'h1);
    chk("t_bad_done", 0, 32'(bus.done), 32'h0);
    run(0, 16'h28A0, 1'b0, 1'b1, -1, -1, oe, od);
    chk("t_retry_match", 0, 32'(bus.match), 32'h1);

    run(0, 16'h5555, 1'b0, 1'b1, 8, -1, oe, od);
    chk("t_extra_end", 0, 32'(oe), 32'd20);
    run(0, 16'hFFFF, 1'b0, 1'b1, 19, -1, oe, od);
    chk("t_stopstart_end", 0, 32'(oe), 32'd20);

    run(0, 16'hBEEF, 1'b0, 1'b1, -1, 10, oe, od);
    chk("t_rst_end", 0, 32'(oe), 32'd10);

    run(3, 16'hC3A5, 1'b0, 1'b1, -1, -1, oe, od);
    chk("t_late_end", 0, 32'(oe), 32'd23);
    chk("t_late_data", 0, 32'(od), 32'hC3A5);

    for (int t = 0; t < 300; t++) begin
      int          d, ke, kr, ee;
      logic [15:0] p;
      bit          bad, resp;
      resp = ($urandom_range(0, 7) != 0);
      d    = $urandom_range(0, TO + 1);
      p    = ($urandom_range(0, 1) != 0) ? EXP : 16'($urandom);
      bad  = ($urandom_range(0, 5) == 0);
      ee   = (resp && d < TO) ? 20 + d : 2 + TO;
      ke   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ee - 1) : -1;
      kr   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ee - 1) : -1;
      run(d, p, bad, resp, ke, kr, oe, od);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cart_unlock_host.md
# cart_unlock_host

Console-side initiator for the cartridge mapper unlock protocol. On request it drives the two-step unlock address sequence (0x5A then 0xA5) onto the cartridge address bus. It then deserializes the framed 18-bit bitstream the mapper returns on its synchronous serial output, checks the frame, and reports the 16-bit payload. It sits in the console bus interface between the boot controller and the cartridge slot, in the same clock domain as the mapper.

## Interface
Parameters:
- TIMEOUT, 8: maximum cycles HUNT waits for the start bit before flagging an error.
- EXPECT, 16'h28A0: payload value that sets MATCH.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  bus clock, shared with the mapper.
- RST  in  1  asynchronous active-high reset.
- START  in  1  single-cycle request to run the unlock sequence; ignored while BUSY.
- ADDR  out  8  cartridge address byte driven during the sequence.
- SI  in  1  serial input from the mapper SO. Idle is 1; a high-Z line is treated as 1 by an external pull-up.
- BUSY  out  1  sequence in progress.
- DONE  out  1  frame received and valid. Sticky until the next accepted START.
- ERR  out  1  timeout or bad stop bit. Sticky until the next accepted START.
- DATA  out  16  received payload, bit 0 first on the wire.
- MATCH  out  1  DONE and DATA == EXPECT.

## Operation
- States: IDLE, ACK, NAK, HUNT, SHIFT, STOP.
- Reset values: state IDLE, ADDR 8'h00, BUSY 0, DONE 0, ERR 0, DATA 16'h0000, MATCH 0, bit counter 0, timeout counter 0.
- IDLE:
  - ADDR = 8'h00.
  - On START, go to ACK and clear DONE, ERR, MATCH and DATA.
- ACK: ADDR = 8'h5A for exactly one cycle, then go to NAK.
- NAK:
  - ADDR = 8'hA5 for exactly one cycle, then go to HUNT with the timeout counter at 0.
  - The mapper loads its frame on the edge that ends this cycle.
- HUNT:
  - ADDR = 8'h00. SI is sampled at every rising edge.
  - SI == 0 means start bit: go to SHIFT with the bit counter at 0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with SI still 1, go to IDLE and set ERR.
- SHIFT:
  - Each edge samples SI into DATA[bit counter], LSB first, then increments the counter.
  - After the 16th sample (counter 15), go to STOP.
- STOP:
  - Sample SI. If 0, set DONE and set MATCH = (DATA == EXPECT). If 1, set ERR.
  - Either way, return to IDLE.
- BUSY = 1 in every state except IDLE.
- START while BUSY is ignored; it is neither queued nor allowed to restart the sequence.
- Retry after ERR is permitted. A mapper left waiting for 0xA5 ignores the 0x5A cycle and still accepts the following 0xA5.
- RST asserted at any point, including mid-SHIFT: immediate return to reset values. A partial DATA is never exposed.
- A START in the same cycle that STOP completes is ignored, because BUSY is still 1 in that cycle.

## Timing
- START sampled at edge T0. ACK occupies cycle T0..T1 and NAK occupies T1..T2.
- Start bit is visible on SI during T2..T3 and is sampled at T3. Payload bits are sampled at T4..T19 and the stop bit at T20.
- DONE/ERR/MATCH are valid from edge T20. BUSY falls at edge T20. Total START-to-DONE latency is 20 cycles for a prompt mapper.
- ADDR is registered and changes only on rising edges; no combinational path from SI to any output.
- Timeout path: with SI held at 1, ERR is set TIMEOUT cycles after entering HUNT (edge T2+TIMEOUT).

## Structure
- Shared package holds:
  - the state enum;
  - ADDR_ACK = 8'h5A, ADDR_NAK = 8'hA5, ADDR_IDLE = 8'h00;
  - FRAME_BITS = 16;
  - the default EXPECT = 16'h28A0, shared with the mapper side so both ends use one constant.
- One natural sub-module, cart_bit_rx: a 16-bit LSB-first deserializer with a shift-enable input, a 4-bit counter and a last-bit flag. The FSM stays in the top.

## Test plan
- Mapper model returns {0, 16'h28A0, 0} after 0x5A/0xA5 -> ADDR sequence 5A, A5, 00; DONE=1, MATCH=1, DATA=16'h28A0, ERR=0 at edge T20.
- Mapper returns payload 16'h1234 -> DONE=1, DATA=16'h1234, MATCH=0.
- SI held at 1 (mapper never responds), TIMEOUT=8 -> ERR=1 at T10, BUSY=0, DONE=0, DATA=0.
- Stop bit forced to 1 -> ERR=1, DONE=0. A following START against a model left in the 0xA5-wait state -> DONE=1, MATCH=1.
- START pulsed again during SHIFT -> ignored, single run completes at T20. RST asserted at T10 -> all outputs at reset values next cycle, ADDR=00.
- Delayed start bit (mapper answers 3 cycles late), TIMEOUT=8 -> DONE=1 at T23, DATA correct.
